// File: rtl/sysmem_pkg.sv
// Shared constants for the system-memory arbiter: default widths, port indices
// and the read-return tag width.
package sysmem_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    localparam int PORT_A     = 0;
    localparam int PORT_B     = 1;
    localparam int TAG_W      = 2;
    localparam int CNT_W      = 8;

    typedef logic [TAG_W-1:0] rd_tag_t;
endpackage

// File: rtl/sysmem_prio_starve.sv
// Fixed-priority grant (B over A) with a starvation counter that forces a
// grant to A once it has lost STARVE_LIMIT consecutive cycles.
module sysmem_prio_starve
    import sysmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic             req_b,
    output logic             grant_a,
    output logic             grant_b,
    output logic [CNT_W-1:0] starve_cnt
);
    logic a_due;

    // No grant is issued while reset is held, so both requesters see waitrequest.
    always_comb begin
        a_due   = (starve_cnt == CNT_W'(STARVE_LIMIT));
        grant_b = reset_n & req_b & ~(req_a & a_due);
        grant_a = reset_n & req_a & ~grant_b;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (grant_a || !req_a)
            starve_cnt <= '0;
        else if (!a_due)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/sysmem_arbiter.sv
// Two-port arbiter in front of the single-port system memory: the Nios data
// master on A, the read-only display scanout on B, one access per cycle.
module sysmem_arbiter
    import sysmem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    output logic              a_waitrequest,
    output logic              a_readdatavalid,
    output logic [DATA_W-1:0] a_readdata,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic              b_read,
    output logic              b_waitrequest,
    output logic              b_readdatavalid,
    output logic [DATA_W-1:0] b_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [CNT_W-1:0]  starve_cnt
);
    logic    req_a, req_b;
    logic    grant_a, grant_b;
    rd_tag_t rd_tag;

    assign req_a = a_read | a_write;
    assign req_b = b_read;

    sysmem_prio_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_a      (req_a),
        .req_b      (req_b),
        .grant_a    (grant_a),
        .grant_b    (grant_b),
        .starve_cnt (starve_cnt)
    );

    // Scanout reads always fetch the whole word.
    always_comb begin
        mem_address    = grant_b ? b_address : a_address;
        mem_byteenable = grant_b ? {BE_W{1'b1}} : a_byteenable;
        mem_writedata  = a_writedata;
        mem_write      = grant_a & a_write;
        mem_chipselect = grant_a | grant_b;
        mem_clken      = 1'b1;
        a_waitrequest  = req_a & ~grant_a;
        b_waitrequest  = req_b & ~grant_b;
    end

    // A simultaneous read+write from A is executed as a write, so no return tag.
    always_ff @(posedge clk) begin
        if (!reset_n)
            rd_tag <= '0;
        else begin
            rd_tag[PORT_A] <= grant_a & a_read & ~a_write;
            rd_tag[PORT_B] <= grant_b & b_read;
        end
    end

    assign a_readdatavalid = rd_tag[PORT_A];
    assign b_readdatavalid = rd_tag[PORT_B];
    assign a_readdata      = mem_readdata;
    assign b_readdata      = mem_readdata;

    // B is read-only; its byteenable is accepted for interface symmetry only.
    logic unused_b_be;
    assign unused_b_be = ^b_byteenable;

    a_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(a_read && a_write));
endmodule

// File: doc/sysmem_arbiter.md
# sysmem_arbiter

- Two-port Avalon-MM arbiter that shares the single-port on-chip system memory (16384 × 32, byte-enabled, registered address, unregistered q) between two requesters:
  - the Nios data master on port A;
  - the snake display/scanout reader on port B.
- Port B has fixed priority; port A is protected by a starvation counter.
- At most one access is issued per cycle.
- Read data is steered back to the issuing port with a one-cycle tag pipeline.
- Sits between the interconnect and the memory instance.

## Interface
Parameters:
- ADDR_W, 14, word address width.
- DATA_W, 32, data width; BE_W = DATA_W/8.
- STARVE_LIMIT, 4, max consecutive cycles port A may lose to port B while requesting; range 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- a_address, b_address  in  ADDR_W  word address.
- a_byteenable, b_byteenable  in  BE_W  byte lanes (writes only; reads return all lanes).
- a_read, b_read  in  1  read request.
- a_write, a_writedata  in  1 / DATA_W  port A write request and data. Port B is read-only.
- a_waitrequest, b_waitrequest  out  1  request not accepted this cycle.
- a_readdatavalid, b_readdatavalid  out  1  readdata valid for that port.
- a_readdata, b_readdata  out  DATA_W  read data.
- mem_address  out  ADDR_W  to memory.
- mem_byteenable  out  BE_W  to memory.
- mem_chipselect  out  1  to memory.
- mem_write  out  1  to memory.
- mem_writedata  out  DATA_W  to memory.
- mem_clken  out  1  to memory.
- mem_readdata  in  DATA_W  from memory.
- starve_cnt  out  8  debug view of starvation counter.

## Operation
Request validity:
- req_A = a_read | a_write; req_B = b_read.
- a_read & a_write together: treat as write; flag in simulation assertion.

Grant, combinational each cycle:
- Only B requesting → B.
- Only A requesting → A.
- Both requesting, starve_cnt < STARVE_LIMIT → B.
- Both requesting, starve_cnt == STARVE_LIMIT → A.
- Neither → none; mem_chipselect = 0.

Memory drive:
- Winner's address/byteenable/writedata go to mem_*.
- mem_chipselect = grant_any; mem_write = grant_A & a_write.
- Port B read: mem_byteenable forced to all ones.
- mem_clken = 1 constant.

Waitrequest:
- x_waitrequest = req_x & ~grant_x.
- Deasserted when idle.
- Requesters hold all signals while waitrequest = 1 (Avalon rule); arbiter does not latch requests.

Starvation counter (starve_cnt, 8 bit):
- Increments when req_A & ~grant_A.
- Clears to 0 when grant_A, or when ~req_A.
- Never exceeds STARVE_LIMIT.

Read return:
- Registered tag rd_tag[1:0] = {grant_B & b_read, grant_A & a_read}, sampled each cycle.
- Next cycle: x_readdatavalid = rd_tag[x].
- a_readdata = b_readdata = mem_readdata (unmuxed; qualified by valid).

Write completion: a write completes in its grant cycle; no response.

## Timing
- Read latency: 1 cycle from accepted cycle (waitrequest = 0 with read high) to readdatavalid.
- Back-to-back reads: one per cycle, returns in issue order, one per cycle.
- Write then read same address, consecutive cycles: read returns new data.
- Reset values: rd_tag = 0, starve_cnt = 0, so both readdatavalid = 0.
- Reset_n low mid-operation:
  - rd_tag is cleared at the reset edge, so a read issued in the reset cycle returns no readdatavalid.
  - While reset_n = 0: mem_chipselect forced 0; waitrequest = req_x.
- Worst-case port A wait with B continuously requesting: STARVE_LIMIT cycles; granted on cycle STARVE_LIMIT+1.
- Combinational path: requests → grant → waitrequest/mem_*. No combinational path from mem_readdata to control.

## Structure
- Shared package sysmem_pkg: ADDR_W/DATA_W defaults, port index constants PORT_A = 0, PORT_B = 1, tag width.
- One sub-module is natural: sysmem_prio_starve, the grant logic plus starvation counter (inputs req_A, req_B; outputs grant_A, grant_B, starve_cnt).
- Datapath mux and tag pipeline stay in the top.

## Test plan
- Single A write 0xDEADBEEF to address 0x0010, byteenable 0xF, then A read 0x0010 → a_waitrequest 0 both cycles; a_readdatavalid high one cycle after the read with 0xDEADBEEF; b_readdatavalid stays 0.
- A write byteenable 0x1 data 0x000000AA onto word 0x11223344 → read returns 0x112233AA.
- B reads continuously; A holds read of 0x0020 with STARVE_LIMIT = 4 → a_waitrequest high 4 cycles, starve_cnt 1..4, A granted cycle 5, starve_cnt back to 0, B waits exactly that one cycle.
- Interleaved A read 0x0001 (data 1) and B read 0x0002 (data 2) on alternate cycles → each valid hits only its own port, with 1 and 2 respectively, one cycle after accept.
- reset_n low in the same cycle an A read is accepted → no a_readdatavalid; starve_cnt = 0; mem_chipselect 0 throughout reset.
- Idle → mem_chipselect 0, both waitrequest 0, both readdatavalid 0.
